// File: rtl/shift_add_mul6.sv
// Iterative 6x6 unsigned shift-and-add multiplier that drives an external
// 6-bit combinational adder; adder6 below is that adder (ports X, Y, S, cout).

module adder6 (
  input  logic [5:0] X,
  input  logic [5:0] Y,
  output logic [5:0] S,
  output logic       cout
);

  assign {cout, S} = {1'b0, X} + {1'b0, Y};

endmodule

module shift_add_mul6 #(
  parameter int W     = 6,
  parameter int STEPS = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product,
  output logic [W-1:0]   add_x,
  output logic [W-1:0]   add_y,
  input  logic [W-1:0]   add_s,
  input  logic           add_cout
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_nxt_s;
  logic [W-1:0]   acc_r;
  logic [W-1:0]   mq_r;
  logic [W-1:0]   mcand_r;
  logic [2:0]     cnt_r;
  logic [2*W-1:0] product_r;
  logic           accept_s;
  logic           step_s;
  logic           last_s;
  logic [2*W-1:0] shift_s;

  // The carry shifts into acc[5], so the 12-bit {acc,mq} never loses a bit.
  assign shift_s = {add_cout, add_s, mq_r[W-1:1]};

  // Next-state decode and datapath control strobes.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    step_s      = 1'b0;
    last_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        step_s = 1'b1;
        if (cnt_r == 3'(STEPS - 1)) begin
          last_s      = 1'b1;
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (start) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand load on accept, one add/shift per RUN cycle, product capture on the last step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r     <= 6'd0;
      mq_r      <= 6'd0;
      mcand_r   <= 6'd0;
      cnt_r     <= 3'd0;
      product_r <= 12'd0;
    end else if (accept_s) begin
      acc_r   <= 6'd0;
      mq_r    <= b;
      mcand_r <= a;
      cnt_r   <= 3'd0;
    end else if (step_s) begin
      {acc_r, mq_r} <= shift_s;
      cnt_r         <= cnt_r + 3'd1;
      if (last_s) begin
        product_r <= shift_s;
      end else begin
        product_r <= product_r;
      end
    end else begin
      acc_r     <= acc_r;
      mq_r      <= mq_r;
      mcand_r   <= mcand_r;
      cnt_r     <= cnt_r;
      product_r <= product_r;
    end
  end

  // Adder operands come from registers only, so add_s never loops back combinationally.
  assign add_x   = (state_r == ST_RUN) ? acc_r : 6'd0;
  assign add_y   = ((state_r == ST_RUN) && mq_r[0]) ? mcand_r : 6'd0;
  assign busy    = (state_r == ST_RUN);
  assign done    = (state_r == ST_DONE);
  assign product = product_r;

endmodule
